// File: rtl/md_unit_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; radix-2, one bit per cycle.
// Optional MD_FAST_MUL_EN: single-cycle multiply path (IDLE -> FIX -> IDLE); divides unchanged.
module md_unit_ctrl #(
   parameter int                DATA_W  = 32,
   parameter logic [DATA_W-1:0] DIV0_LO = {DATA_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MdStartE,
   input  logic [1:0]        MdOpE,
   input  logic [DATA_W-1:0] SrcAE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic              MdReadE,
   input  logic              HiLoWriteE,
   input  logic              HiLoSelE,
   input  logic              FlushE,
   output logic [DATA_W-1:0] HiLoOutE,
   output logic              MdBusyE,
   output logic              MdStallE,
   output logic              MdDoneE
);
   localparam int CW = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   hi_q, lo_q;
   logic [DATA_W-1:0]   op_q;      // multiplicand (mul) or divisor (div) magnitude
   logic [2*DATA_W-1:0] acc_q;     // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [2*DATA_W-1:0] acc_d;
   logic [CW-1:0]       cnt_q;
   logic                is_div_q, neg_res_q, neg_a_q, done_q;

   logic                signed_op, start;
   logic [DATA_W-1:0]   mag_a, mag_b;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W+1:0]   div_diff;
   logic [2*DATA_W-1:0] prod_s;
   logic [DATA_W-1:0]   quo_s, rem_s;

   assign signed_op = ~MdOpE[0];
   assign start     = (state_q == IDLE) & MdStartE & ~FlushE;
   assign mag_a     = (signed_op & SrcAE[DATA_W-1])      ? -SrcAE      : SrcAE;
   assign mag_b     = (signed_op & WriteDataE[DATA_W-1]) ? -WriteDataE : WriteDataE;

   assign MdBusyE  = (state_q != IDLE);
   assign MdStallE = MdBusyE & (MdStartE | MdReadE | HiLoWriteE);
   assign MdDoneE  = done_q;
   assign HiLoOutE = HiLoSelE ? hi_q : lo_q;

`ifdef MD_FAST_MUL_EN
   logic [2*DATA_W-1:0] fast_prod;
   assign fast_prod = {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
`endif

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, op_q} : '0);
      div_diff = {1'b0, acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]} - {2'b00, op_q};
      acc_d    = {mul_sum, acc_q[DATA_W-1:1]};
      if (is_div_q)
         // Borrow means restore: the whole {rem,quo} pair just shifts left with a 0 bit.
         acc_d = div_diff[DATA_W+1] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                    : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
   end

   // With a zero divisor every step succeeds, so the remainder ends up holding |dividend|
   // and re-applying the dividend sign yields the original value for HI.
   assign prod_s = neg_res_q ? -acc_q : acc_q;
   assign quo_s  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
   assign rem_s  = neg_a_q   ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q   <= IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         op_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_a_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  is_div_q  <= MdOpE[1];
                  neg_res_q <= signed_op & (SrcAE[DATA_W-1] ^ WriteDataE[DATA_W-1]);
                  neg_a_q   <= signed_op & SrcAE[DATA_W-1];
                  cnt_q     <= '0;
                  op_q      <= MdOpE[1] ? mag_b : mag_a;
                  acc_q     <= MdOpE[1] ? {{DATA_W{1'b0}}, mag_a} : {{DATA_W{1'b0}}, mag_b};
                  state_q   <= CALC;
`ifdef MD_FAST_MUL_EN
                  if (!MdOpE[1]) begin
                     acc_q   <= fast_prod;
                     state_q <= FIX;
                  end
`endif
               end else if (HiLoWriteE && !FlushE) begin
                  if (HiLoSelE) hi_q <= SrcAE;
                  else          lo_q <= SrcAE;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(DATA_W-1)) state_q <= FIX;
            end
            FIX: begin
               if (is_div_q) begin
                  hi_q <= rem_s;
                  lo_q <= (op_q == '0) ? DIV0_LO : quo_s;
               end else begin
                  hi_q <= prod_s[2*DATA_W-1:DATA_W];
                  lo_q <= prod_s[DATA_W-1:0];
               end
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Randomized bench for md_unit_ctrl against an arithmetic HI/LO reference model.
module tb_md_unit_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        MdStartE, MdReadE, HiLoWriteE, HiLoSelE, FlushE;
   logic [1:0]  MdOpE;
   logic [31:0] SrcAE, WriteDataE, HiLoOutE;
   logic        MdBusyE, MdStallE, MdDoneE;

   int n_cmp = 0;
   int n_err = 0;

   md_unit_ctrl dut (
      .clk(clk), .rst_n(rst_n), .MdStartE(MdStartE), .MdOpE(MdOpE), .SrcAE(SrcAE),
      .WriteDataE(WriteDataE), .MdReadE(MdReadE), .HiLoWriteE(HiLoWriteE),
      .HiLoSelE(HiLoSelE), .FlushE(FlushE), .HiLoOutE(HiLoOutE), .MdBusyE(MdBusyE),
      .MdStallE(MdStallE), .MdDoneE(MdDoneE)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; C-style truncating divide, remainder follows dividend.
   task automatic ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
      longint          sa, sb, q, r;
      longint unsigned p;
      sa = $signed(a);
      sb = $signed(b);
      hi = '0; lo = '0;
      case (op)
         2'd0: begin q = sa * sb; hi = q[63:32]; lo = q[31:0]; end
         2'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
         default: begin
            if (b == 0) begin
               hi = a; lo = 32'hFFFFFFFF;
            end else if (op == 2'd2) begin
               q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
            end else begin
               hi = a % b; lo = a / b;
            end
         end
      endcase
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      HiLoSelE = 1'b1; #1 hi = HiLoOutE;
      HiLoSelE = 1'b0; #1 lo = HiLoOutE;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit with_read);
      int          busy, stall, guard, early_done, exp_busy;
      logic [31:0] eh, el, gh, gl;
      exp_busy = 33;
`ifdef MD_FAST_MUL_EN
      if (!op[1]) exp_busy = 1;
`endif
      ref_md(op, a, b, eh, el);
      @(negedge clk);
      MdOpE = op; SrcAE = a; WriteDataE = b; MdStartE = 1'b1;
      @(negedge clk);
      MdStartE = 1'b0;
      if (with_read) begin MdReadE = 1'b1; HiLoSelE = 1'b0; end
      busy = 0; stall = 0; guard = 0; early_done = 0;
      while (MdBusyE === 1'b1 && guard < 100) begin
         busy++;
         if (MdStallE === 1'b1) stall++;
         if (MdDoneE === 1'b1) early_done++;
         @(negedge clk);
         guard++;
      end
      chk($sformatf("busy_cycles op%0d", op), busy, exp_busy);
      chk("done_during_busy", early_done, 0);
      if (with_read) begin
         chk("stall_cycles", stall, exp_busy);
         chk("stall_drop", MdStallE, 1'b0);
         chk("mflo_first_idle", HiLoOutE, el);
         MdReadE = 1'b0;
      end
      chk("done_pulse", MdDoneE, 1'b1);
      read_hilo(gh, gl);
      chk($sformatf("HI op%0d %h,%h", op, a, b), gh, eh);
      chk($sformatf("LO op%0d %h,%h", op, a, b), gl, el);
      @(negedge clk);
      chk("done_one_cycle", MdDoneE, 1'b0);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] gh, gl, wh, wl;
      int          bad;
      rst_n = 1'b1; MdStartE = 0; MdReadE = 0; HiLoWriteE = 0; HiLoSelE = 0; FlushE = 0;
      MdOpE = 0; SrcAE = 0; WriteDataE = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", MdBusyE, 1'b0);
      chk("rst_stall", MdStallE, 1'b0);
      chk("rst_done", MdDoneE, 1'b0);
      read_hilo(gh, gl);
      chk("rst_hilo", {gh, gl}, 64'h0);
      rst_n = 1'b0;

      run_op(2'd0, 32'hFFFFFFFF, 32'h00000002, 1'b0);
      run_op(2'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0);
      run_op(2'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0);
      run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op(2'd3, 32'h00000007, 32'h00000000, 1'b0);
      run_op(2'd2, 32'hFFFFFFF9, 32'h00000000, 1'b0);
      run_op(2'd0, 32'h12345678, 32'hFEDCBA98, 1'b1);
      run_op(2'd2, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b1);
      for (int i = 0; i < 14; i++)
         run_op(2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));

      // MTHI / MTLO, and flushed MTHI that must not land
      wh = $urandom; wl = $urandom;
      @(negedge clk); HiLoWriteE = 1; HiLoSelE = 1; SrcAE = wh;
      @(negedge clk); HiLoSelE = 0; SrcAE = wl;
      @(negedge clk); HiLoSelE = 1; SrcAE = ~wh; FlushE = 1;
      @(negedge clk); HiLoWriteE = 0; FlushE = 0;
      read_hilo(gh, gl);
      chk("mthi", gh, wh);
      chk("mtlo", gl, wl);

      // Reset in the middle of a divide: abandon without HI/LO update or done
      @(negedge clk); MdOpE = 2'd2; SrcAE = 32'd1000; WriteDataE = 32'd7; MdStartE = 1;
      @(negedge clk); MdStartE = 0;
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); rst_n = 1'b0;
      chk("midop_rst_busy", MdBusyE, 1'b0);
      read_hilo(gh, gl);
      chk("midop_rst_hilo", {gh, gl}, 64'h0);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (MdDoneE !== 1'b0 || MdBusyE !== 1'b0) bad++;
      end
      chk("no_done_after_rst", bad, 0);

      // Flushed start is not accepted
      @(negedge clk); MdOpE = 2'd1; SrcAE = 32'd3; WriteDataE = 32'd5; MdStartE = 1; FlushE = 1;
      @(negedge clk); MdStartE = 0; FlushE = 0;
      chk("flush_start_busy", MdBusyE, 1'b0);
      @(negedge clk);
      chk("flush_start_busy2", MdBusyE, 1'b0);

      run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no end expected finish");
      $fatal(1, "timeout");
   end
endmodule
